// File: rtl/peripheral_wb_pkg.sv
// Shared Wishbone definitions: cycle-type and burst-type codes, slave FSM states
// and the wrap-burst mask helper.
package peripheral_wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK,
    ST_BURST,
    ST_ERR
  } wb_slave_state_t;

  // Word-index bits that rotate inside a wrapping burst (0 for linear).
  function automatic logic [3:0] wrap_mask(input logic [1:0] bte);
    case (bte)
      BTE_WRAP4:  wrap_mask = 4'h3;
      BTE_WRAP8:  wrap_mask = 4'h7;
      BTE_WRAP16: wrap_mask = 4'hF;
      default:    wrap_mask = 4'h0;
    endcase
  endfunction

endpackage

// File: rtl/peripheral_wb_slave_mem_ram.sv
// DEPTH x DW single-port RAM with byte write enables and a registered read.
// Kept as a separate block so a technology macro can drop in.
module peripheral_wb_slave_mem_ram #(
  parameter int DW    = 32,
  parameter int DEPTH = 256,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [DW/8-1:0] sel_i,
  input  logic [IW-1:0]   addr_i,
  input  logic [DW-1:0]   wdata_i,
  output logic [DW-1:0]   rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < DW/8; b++) begin
        if (sel_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/peripheral_wb_slave_mem.sv
// Wishbone B4 slave RAM with first-beat wait states and byte-lane writes.
// Define PERIPHERAL_WB_BURST_EN to add incrementing/wrapping registered-feedback bursts.
module peripheral_wb_slave_mem
  import peripheral_wb_pkg::*;
#(
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic            wb_clk,
  input  logic            wb_rst_n,
  input  logic [AW-1:0]   wb_adr_i,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic            wb_we_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic [2:0]      wb_cti_i,
  input  logic [1:0]      wb_bte_i,
  output logic [DW-1:0]   wb_dat_o,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic            wb_rty_o
);

  localparam int         OFF = $clog2(DW/8);
  localparam int         IW  = $clog2(DEPTH);
  localparam logic [3:0] WS  = WAIT_STATES[3:0];

  wb_slave_state_t state_q;
  logic [IW-1:0]   idx_q;
  logic [IW-1:0]   bus_idx;
  logic [IW-1:0]   ram_addr;
  logic [3:0]      cnt_q;
  logic            we_q;
  logic            oor_q;
  logic            ack_q;
  logic            err_q;
  logic            bus_oor;
  logic            ram_we;
  logic [DW-1:0]   ram_q;
  logic            unused_in;

  assign bus_idx   = wb_adr_i[OFF +: IW];
  assign bus_oor   = |wb_adr_i[AW-1:OFF+IW];
  assign ram_we    = ack_q & we_q & wb_cyc_i & wb_stb_i;
  assign unused_in = ^{wb_adr_i, wb_cti_i, wb_bte_i};

`ifdef PERIPHERAL_WB_BURST_EN
  logic [1:0]    bte_q;
  logic [IW-1:0] idx_inc;
  logic [IW-1:0] wrap_m;
  logic [IW-1:0] burst_idx_d;
  logic          burst_cross;

  assign idx_inc     = idx_q + IW'(1);
  assign wrap_m      = IW'(wrap_mask(bte_q));
  assign burst_idx_d = (bte_q == BTE_LINEAR) ? idx_inc
                                             : ((idx_q & ~wrap_m) | (idx_inc & wrap_m));
  assign burst_cross = (bte_q == BTE_LINEAR) && (&idx_q);
`endif

  // The RAM read is issued one edge ahead so data lines up with ack;
  // during a write beat the single port is given to the write.
  always_comb begin
    ram_addr = idx_q;
    if (state_q == ST_IDLE) begin
      ram_addr = bus_idx;
    end
`ifdef PERIPHERAL_WB_BURST_EN
    else if (ack_q && !we_q) begin
      ram_addr = burst_idx_d;
    end
`endif
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      oor_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef PERIPHERAL_WB_BURST_EN
      bte_q   <= BTE_LINEAR;
`endif
    end else if (!wb_cyc_i) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (wb_stb_i) begin
            idx_q <= bus_idx;
            we_q  <= wb_we_i;
            oor_q <= bus_oor;
            cnt_q <= WS;
`ifdef PERIPHERAL_WB_BURST_EN
            bte_q <= wb_bte_i;
`endif
            if (WS == 4'd0) begin
              if (bus_oor) begin
                state_q <= ST_ERR;
                err_q   <= 1'b1;
              end else begin
                state_q <= ST_ACK;
                ack_q   <= 1'b1;
              end
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            if (oor_q) begin
              state_q <= ST_ERR;
              err_q   <= 1'b1;
            end else begin
              state_q <= ST_ACK;
              ack_q   <= 1'b1;
            end
          end
        end
        ST_ACK, ST_BURST: begin
          state_q <= ST_IDLE;
`ifdef PERIPHERAL_WB_BURST_EN
          if (wb_stb_i && wb_cti_i == CTI_INC) begin
            idx_q <= burst_idx_d;
            if (burst_cross) begin
              state_q <= ST_ERR;
              err_q   <= 1'b1;
            end else begin
              state_q <= ST_BURST;
              ack_q   <= 1'b1;
            end
          end
`endif
        end
        ST_ERR: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  peripheral_wb_slave_mem_ram #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_ram (
    .clk_i   (wb_clk),
    .we_i    (ram_we),
    .sel_i   (wb_sel_i),
    .addr_i  (ram_addr),
    .wdata_i (wb_dat_i),
    .rdata_o (ram_q)
  );

  assign wb_dat_o = ack_q ? ram_q : '0;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_rty_o = 1'b0;

endmodule
